// File: rtl/video_pattern_source_pkg.sv
// Shared video definitions: pattern and FSM encodings, colour-bar table and
// the saturating cast helper reused by the colour-correction blocks.
package video_pattern_source_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vstate_e;

    // Bars in display order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    function automatic logic [7:0] sat_u8(input logic [7:0] y, input logic [7:0] cast);
        logic signed [9:0] s;
        logic [7:0]        res;
        s = $signed({2'b00, y}) + $signed({{2{cast[7]}}, cast});
        if (s < 10'sd0)
            res = '0;
        else if (s > 10'sd255)
            res = '1;
        else
            res = s[7:0];
        return res;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing: run/drain FSM, h/v counters, region flags and frame pulses.
module video_timing_gen
    import video_pattern_source_pkg::*;
#(
    parameter int I_w    = 1920,
    parameter int I_h    = 1080,
    parameter int H_FP   = 88,
    parameter int H_SYNC = 44,
    parameter int H_BP   = 148,
    parameter int V_FP   = 4,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 36,
    localparam int H_TOTAL = I_w + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = I_h + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_running,
    output logic          o_active,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_frame_start,
    output logic          o_frame_end,
    output logic          o_line_end
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LS = HW'(I_w - 1);
    localparam logic [VW-1:0] V_ACT_LS = VW'(I_h - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(I_w + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(I_w + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(I_h + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(I_h + V_FP + V_SYNC - 1);

    vstate_e       r_state, w_state_nxt;
    logic          r_en;
    logic [HW-1:0] r_h, w_h_nxt;
    logic [VW-1:0] r_v, w_v_nxt;
    logic          w_running, w_line_end, w_frame_end;

    assign w_running   = (r_state != ST_IDLE);
    assign w_line_end  = w_running && (r_h == H_LAST);
    assign w_frame_end = w_line_end && (r_v == V_LAST);

    // En is registered first, giving the two-edge start-up latency to the first output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= i_en;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        case (r_state)
            ST_IDLE:  if (r_en) w_state_nxt = ST_RUN;
            // A stop request on the very last pixel has nothing left to drain.
            ST_RUN:   if (!r_en) w_state_nxt = w_frame_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (w_frame_end) w_state_nxt = r_en ? ST_RUN : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_running) begin
            if (w_line_end) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_h_nxt = r_h + 1'b1;
            end
        end
    end

    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_running     = w_running;
    assign o_active      = w_running && (r_h <= H_ACT_LS) && (r_v <= V_ACT_LS);
    assign o_hsync       = w_running && (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    assign o_vsync       = w_running && (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    assign o_frame_start = w_running && (r_h == '0) && (r_v == '0);
    assign o_frame_end   = w_frame_end;
    assign o_line_end    = w_line_end;

endmodule

// File: rtl/video_pattern_source.sv
// RGB888 test-pattern source on the Pre_* pixel interface, with frame-shadowed
// pattern/cast controls and fully registered outputs.
module video_pattern_source
    import video_pattern_source_pkg::*;
#(
    parameter int I_w    = 1920,
    parameter int I_h    = 1080,
    parameter int H_FP   = 88,
    parameter int H_SYNC = 44,
    parameter int H_BP   = 148,
    parameter int V_FP   = 4,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 36
) (
    input  logic        Pre_CLK,
    input  logic        Pre_Rst_n,
    input  logic        En,
    input  logic [1:0]  Pattern_Sel,
    input  logic [7:0]  Cast_R,
    input  logic [7:0]  Cast_B,
    input  logic [23:0] Solid_RGB,
    output logic        Pre_Vsync,
    output logic        Pre_Hsync,
    output logic        Pre_de,
    output logic [7:0]  Pre_Pixel_R,
    output logic [7:0]  Pre_Pixel_G,
    output logic [7:0]  Pre_Pixel_B,
    output logic        Frame_Start,
    output logic [15:0] Frame_Cnt
);

    localparam int H_TOTAL = I_w + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = I_h + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = I_w / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_running, w_active, w_hsync, w_vsync;
    logic          w_frame_start, w_frame_end, w_line_end;

    video_timing_gen #(
        .I_w(I_w), .I_h(I_h),
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk(Pre_CLK), .i_rst_n(Pre_Rst_n), .i_en(En),
        .o_h(w_h), .o_v(w_v),
        .o_running(w_running), .o_active(w_active),
        .o_hsync(w_hsync), .o_vsync(w_vsync),
        .o_frame_start(w_frame_start), .o_frame_end(w_frame_end),
        .o_line_end(w_line_end)
    );

    pattern_e      r_pat;
    logic [7:0]    r_cast_r, r_cast_b;
    logic [23:0]   r_solid;
    logic [BW-1:0] r_bar_px;
    logic [2:0]    r_bar;

    pattern_e      w_pat;
    logic [7:0]    w_cast_r, w_cast_b, w_y, w_ramp_y;
    logic [23:0]   w_solid, w_rgb;
    logic          w_chk;

    // The frame's first pixel already uses the values being captured on that cycle.
    assign w_pat    = w_frame_start ? pattern_e'(Pattern_Sel) : r_pat;
    assign w_cast_r = w_frame_start ? Cast_R    : r_cast_r;
    assign w_cast_b = w_frame_start ? Cast_B    : r_cast_b;
    assign w_solid  = w_frame_start ? Solid_RGB : r_solid;

    assign w_ramp_y = 8'(w_h);
    assign w_chk    = |((32'(w_h) ^ 32'(w_v)) & 32'h20);

    always_ff @(posedge Pre_CLK or negedge Pre_Rst_n) begin
        if (!Pre_Rst_n) begin
            r_pat    <= PAT_BARS;
            r_cast_r <= '0;
            r_cast_b <= '0;
            r_solid  <= '0;
            r_bar_px <= '0;
            r_bar    <= '0;
        end else begin
            if (w_frame_start) begin
                r_pat    <= pattern_e'(Pattern_Sel);
                r_cast_r <= Cast_R;
                r_cast_b <= Cast_B;
                r_solid  <= Solid_RGB;
            end
            if (!w_running || w_line_end) begin
                r_bar_px <= '0;
                r_bar    <= '0;
            end else if (r_bar_px == BAR_LAST) begin
                r_bar_px <= '0;
                r_bar    <= r_bar + 1'b1;
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        w_y   = '0;
        case (w_pat)
            PAT_BARS:  w_rgb = bar_rgb(r_bar);
            PAT_RAMP:  w_rgb = {sat_u8(w_ramp_y, w_cast_r), w_ramp_y, sat_u8(w_ramp_y, w_cast_b)};
            PAT_SOLID: w_rgb = w_solid;
            PAT_CHECK: begin
                w_y   = w_chk ? 8'hFF : 8'h00;
                w_rgb = {sat_u8(w_y, w_cast_r), w_y, sat_u8(w_y, w_cast_b)};
            end
            default:   w_rgb = '0;
        endcase
    end

    always_ff @(posedge Pre_CLK or negedge Pre_Rst_n) begin
        if (!Pre_Rst_n) begin
            Pre_Vsync   <= 1'b0;
            Pre_Hsync   <= 1'b0;
            Pre_de      <= 1'b0;
            Pre_Pixel_R <= '0;
            Pre_Pixel_G <= '0;
            Pre_Pixel_B <= '0;
            Frame_Start <= 1'b0;
            Frame_Cnt   <= '0;
        end else begin
            Pre_Vsync   <= w_vsync;
            Pre_Hsync   <= w_hsync;
            Pre_de      <= w_active;
            Pre_Pixel_R <= w_active ? w_rgb[23:16] : 8'h00;
            Pre_Pixel_G <= w_active ? w_rgb[15:8]  : 8'h00;
            Pre_Pixel_B <= w_active ? w_rgb[7:0]   : 8'h00;
            Frame_Start <= w_frame_start;
            if (w_frame_end)
                Frame_Cnt <= Frame_Cnt + 16'd1;
        end
    end

endmodule
